// File: rtl/wiphy_pkg.sv
// Shared baseband types: sample amplitude, phase argument and the
// per-frame phase-ramp configuration word.
package wiphy_pkg;

  localparam int AMP_W = 16;
  localparam int ARG_W = 2 * AMP_W;

  typedef logic signed [AMP_W-1:0] amp_t;
  typedef logic signed [ARG_W-1:0] arg_t;

  // Phase units: the full arg_t range spans one turn (2*pi).
  localparam arg_t PI   = arg_t'({1'b1, {(ARG_W-1){1'b0}}});
  localparam arg_t PI_2 = arg_t'({2'b01, {(ARG_W-2){1'b0}}});

  typedef struct packed {
    arg_t phase0;
    arg_t inc;
  } cfg_t;

  // Phase advance; wraps silently modulo one turn.
  function automatic arg_t phase_step(input arg_t a, input arg_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/cfo_sequencer_cfg_slot.sv
// One-entry valid/ready holding register for a frame configuration.
// Used as the shadow slot that lets the next frame's config wait
// while the current frame is still streaming.
module cfg_slot
  import wiphy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  cfg_t in_data,
  output logic out_valid,
  input  logic out_ready,
  output cfg_t out_data
);

  logic full_reg;
  cfg_t data_reg;

  assign in_ready  = !full_reg;
  assign out_valid = full_reg;
  assign out_data  = data_reg;

  // Fill on push, empty on pop; push only happens while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else begin
      if (out_valid && out_ready) begin
        full_reg <= 1'b0;
      end
      if (in_valid && in_ready) begin
        full_reg <= 1'b1;
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/cfo_sequencer.sv
// Per-frame phase sequencer ahead of the CORDIC rotator. Tags every
// I/Q sample with a phase that starts at phase0 and advances by inc
// per sample, producing {phase, q, i} words for the rotator.
module cfo_sequencer
  import wiphy_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [4*WIDTH-1:0] cfg_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*WIDTH-1:0] s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [4*WIDTH-1:0] m_data,
  output logic               m_last,
  output logic               busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg;
  arg_t               acc_reg;
  arg_t               inc_reg;
  logic               m_valid_reg;
  logic               m_last_reg;
  logic [4*WIDTH-1:0] m_data_reg;

  cfg_t cfg_in;
  cfg_t shadow_cfg;
  logic shadow_full;
  logic shadow_empty;
  logic cfg_fire;
  logic s_fire;
  logic last_fire;
  logic shadow_push;
  logic shadow_pop;

  assign cfg_in    = cfg_t'(cfg_data);
  assign cfg_ready = shadow_empty;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign s_ready   = (state_reg == RUN) && (!m_valid_reg || m_ready);
  assign s_fire    = s_valid && s_ready;
  assign last_fire = s_fire && s_last;

  // A config arriving mid-frame waits in the shadow, except when it lands
  // on the frame's last sample: then it is loaded straight into the active
  // registers so the next frame starts without a bubble.
  assign shadow_push = cfg_fire && (state_reg == RUN) && !last_fire;
  assign shadow_pop  = shadow_full && ((state_reg == IDLE) || last_fire);

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_last  = m_last_reg;
  assign busy    = (state_reg == RUN) || m_valid_reg;

  cfg_slot u_shadow (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (shadow_push),
    .in_ready  (shadow_empty),
    .in_data   (cfg_in),
    .out_valid (shadow_full),
    .out_ready (shadow_pop),
    .out_data  (shadow_cfg)
  );

  // Frame FSM, phase accumulator and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      inc_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (shadow_full) begin
            acc_reg   <= shadow_cfg.phase0;
            inc_reg   <= shadow_cfg.inc;
            state_reg <= RUN;
          end else if (cfg_fire) begin
            acc_reg   <= cfg_in.phase0;
            inc_reg   <= cfg_in.inc;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (last_fire) begin
            if (shadow_full) begin
              acc_reg <= shadow_cfg.phase0;
              inc_reg <= shadow_cfg.inc;
            end else if (cfg_fire) begin
              acc_reg <= cfg_in.phase0;
              inc_reg <= cfg_in.inc;
            end else begin
              state_reg <= IDLE;
            end
          end else if (s_fire) begin
            acc_reg <= phase_step(acc_reg, inc_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (s_fire) begin
        m_data_reg  <= {acc_reg, s_data};
        m_last_reg  <= s_last;
        m_valid_reg <= 1'b1;
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cfo_sequencer.sv
// Self-checking bench for cfo_sequencer. Frames are described at the
// level of "config + N samples"; the expected output of sample n is
// phase0 + n*inc with the I/Q word unchanged.
module tb_cfo_sequencer;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [4*W-1:0] cfg_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [2*W-1:0] s_data = '0;
  logic           s_last = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [4*W-1:0] m_data;
  logic           m_last;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] cfg_q[$];
  logic [32:0] smp_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  int          obs_cyc[$];

  cfo_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    cfg_data  = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    m_ready   = 1'b0;
  endtask

  task automatic clear_model();
    cfg_q.delete();
    smp_q.delete();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Queue one frame and its expected outputs.
  task automatic add_frame(input logic [31:0] p0, input logic [31:0] inc,
                           input int n, input bit fixed, input logic [31:0] fdata);
    logic [31:0] d;
    logic [31:0] ph;
    cfg_q.push_back({p0, inc});
    for (int j = 0; j < n; j++) begin
      d  = fixed ? fdata : $urandom();
      ph = p0 + inc * 32'(j);
      smp_q.push_back({(j == n - 1), d});
      exp_q.push_back({(j == n - 1), ph, d});
    end
  endtask

  // Drive queued configs/samples, consume outputs and compare them in order.
  // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  task automatic pump(input int ready_mode, input int gap_pct,
                      input int stop_after, input int budget);
    int          k = 0;
    int          n = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic [64:0] want;
    while (1) begin
      @(negedge clk);
      cfg_valid = (cfg_q.size() > 0);
      cfg_data  = cfg_valid ? cfg_q[0] : '0;
      if (smp_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        s_valid = 1'b1;
        {s_last, s_data} = smp_q[0];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
      end
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: m_ready = 1'($urandom_range(1));
      endcase
      #1;
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          bad++;
          $display("FAIL hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (cfg_valid && cfg_ready) void'(cfg_q.pop_front());
      if (s_valid && s_ready) void'(smp_q.pop_front());
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_out: got %h want none", {m_last, m_data});
        end else begin
          want = exp_q.pop_front();
          $display("xfer cyc=%0d phase=%h q=%h i=%h last=%b", cyc,
                   m_data[63:32], m_data[31:16], m_data[15:0], m_last);
          if ({m_last, m_data} !== want) begin
            bad++;
            $display("FAIL out_word: got %h want %h", {m_last, m_data}, want);
          end
        end
        obs_q.push_back({m_last, m_data});
        obs_cyc.push_back(cyc);
        n++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      k++;
      cyc++;
      if (stop_after > 0 && n >= stop_after) break;
      if (cfg_q.size() == 0 && smp_q.size() == 0 && exp_q.size() == 0) break;
      if (k > budget) begin
        total++;
        bad++;
        $display("FAIL timeout: got %0d outstanding want 0", exp_q.size());
        break;
      end
    end
    if (stop_after == 0) begin
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    #1;
    total += 6;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    if (m_data !== 64'h0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
    if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [31:0] ph_tab [5];
    ph_tab = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    clear_model();
    add_frame(32'h0, 32'h4000_0000, 5, 1'b0, 32'h0);
    pump(0, 0, 0, 200);
    total++;
    if (obs_q.size() != 5) begin
      bad++;
      $display("FAIL single_count: got %0d want 5", obs_q.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        total += 2;
        if (obs_q[j][63:32] !== ph_tab[j]) begin
          bad++;
          $display("FAIL single_phase%0d: got %h want %h", j, obs_q[j][63:32], ph_tab[j]);
        end
        if (obs_q[j][64] !== (j == 4)) begin
          bad++;
          $display("FAIL single_last%0d: got %b want %b", j, obs_q[j][64], (j == 4));
        end
      end
    end
  endtask

  task automatic test_no_config();
    do_reset();
    clear_model();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = $urandom();
      m_ready = 1'b1;
      #1;
      total += 2;
      if (s_ready !== 1'b0) begin bad++; $display("FAIL nocfg_s_ready: got %b want 0", s_ready); end
      if (m_valid !== 1'b0) begin bad++; $display("FAIL nocfg_m_valid: got %b want 0", m_valid); end
    end
    add_frame(32'h1000_0000, 32'h1, 2, 1'b0, 32'h0);
    pump(0, 0, 0, 200);
    total++;
    if (obs_q.size() != 2) begin
      bad++;
      $display("FAIL nocfg_count: got %0d want 2", obs_q.size());
    end else begin
      total += 2;
      if (obs_q[0][63:32] !== 32'h1000_0000) begin
        bad++; $display("FAIL nocfg_ph0: got %h want 10000000", obs_q[0][63:32]);
      end
      if (obs_q[1][63:32] !== 32'h1000_0001) begin
        bad++; $display("FAIL nocfg_ph1: got %h want 10000001", obs_q[1][63:32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_model();
    add_frame(32'h0, 32'h100, 3, 1'b0, 32'h0);
    add_frame(32'h7FFF_FFFF, 32'h1, 2, 1'b0, 32'h0);
    pump(0, 0, 0, 200);
    total++;
    if (obs_q.size() != 5) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 5", obs_q.size());
    end else begin
      total += 3;
      if (obs_q[3][63:32] !== 32'h7FFF_FFFF) begin
        bad++; $display("FAIL b2b_ph0: got %h want 7fffffff", obs_q[3][63:32]);
      end
      if (obs_q[4][63:32] !== 32'h8000_0000) begin
        bad++; $display("FAIL b2b_ph1: got %h want 80000000", obs_q[4][63:32]);
      end
      if (obs_cyc[3] != obs_cyc[2] + 1) begin
        bad++; $display("FAIL b2b_gap: got cycle %0d want %0d", obs_cyc[3], obs_cyc[2] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] inc;
    inc = $urandom();
    clear_model();
    add_frame($urandom(), inc, 8, 1'b0, 32'h0);
    pump(1, 0, 0, 400);
    total++;
    if (obs_q.size() != 8) begin
      bad++;
      $display("FAIL bp_count: got %0d want 8", obs_q.size());
    end else begin
      for (int j = 1; j < 8; j++) begin
        total++;
        if (obs_q[j][63:32] - obs_q[j-1][63:32] !== inc) begin
          bad++;
          $display("FAIL bp_step%0d: got %h want %h", j,
                   obs_q[j][63:32] - obs_q[j-1][63:32], inc);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    clear_model();
    add_frame($urandom(), $urandom(), 2, 1'b1, 32'h7FFF_8000);
    pump(0, 0, 0, 200);
    total++;
    if (obs_q.size() != 2) begin
      bad++;
      $display("FAIL pass_count: got %0d want 2", obs_q.size());
    end else begin
      total++;
      if (obs_q[0][31:0] !== 32'h7FFF_8000) begin
        bad++; $display("FAIL pass_iq: got %h want 7fff8000", obs_q[0][31:0]);
      end
    end
  endtask

  task automatic test_random();
    int n_exp = 0;
    int len;
    clear_model();
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(8, 1);
      n_exp += len;
      add_frame($urandom(), $urandom(), len, 1'b0, 32'h0);
    end
    pump(2, 30, 0, 2000);
    total++;
    if (obs_q.size() != n_exp) begin
      bad++;
      $display("FAIL rand_count: got %0d want %0d", obs_q.size(), n_exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    clear_model();
    add_frame($urandom(), $urandom(), 6, 1'b0, 32'h0);
    add_frame(32'h0, 32'h1, 3, 1'b0, 32'h0);
    pump(0, 0, 2, 200);
    @(posedge clk);
    #2;
    total += 2;
    if (cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_shadow_full: got %b want 0", cfg_ready); end
    if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_pending: got %b want 1", m_valid); end
    reset = 1'b0;
    idle_inputs();
    #1;
    total += 4;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_cfg_ready: got %b want 1", cfg_ready); end
    if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_s_ready: got %b want 0", s_ready); end
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    add_frame(32'h2000_0000, 32'h3, 3, 1'b0, 32'h0);
    pump(0, 0, 0, 200);
    total++;
    if (obs_q.size() != 3) begin
      bad++;
      $display("FAIL mid_post_count: got %0d want 3", obs_q.size());
    end else begin
      total++;
      if (obs_q[0][63:32] !== 32'h2000_0000) begin
        bad++; $display("FAIL mid_post_ph0: got %h want 20000000", obs_q[0][63:32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_no_config();
    test_back_to_back();
    test_backpressure();
    test_passthrough();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
